// File: rtl/dot_vector_loader.sv
// dot_vector_loader: collects (a,b) element pairs from a valid/ready stream
// into packed lane vectors and presents them to the dot-product datapath.
//
// Parameters:
//   N          lanes per vector (N >= 2), 32 bits per lane
//   CW         width of out_count
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   element pair offered
//   in_ready   loader can accept a pair (FILL state)
//   in_a/in_b  32-bit elements of vectors A and B
//   in_last    offered pair ends the current vector
//   vector_a   packed A, lane i at [32*i+31:32*i]
//   vector_b   packed B, same packing
//   out_count  number of valid lanes presented (1..N)
//   out_valid  packed vectors complete and stable (FULL state)
//   out_ready  consumer accepts the vectors
module dot_vector_loader #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_last,
  output logic [32*N-1:0] vector_a,
  output logic [32*N-1:0] vector_b,
  output logic [CW-1:0]   out_count,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wr_en;
  logic          clr;
  logic          close;

  logic [31:0] lane_a_q [N];
  logic [31:0] lane_b_q [N];

  // A vector closes on in_last or when the last lane is written,
  // so idx never wraps past N-1.
  assign close = in_last || (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (close) begin
            state_d = FULL;
            cnt_d   = CW'(idx_q) + CW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lanes are cleared when a vector is consumed so that a following
  // short vector presents zeros in its unused lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || clr) begin
        lane_a_q[i] <= '0;
        lane_b_q[i] <= '0;
      end else if (wr_en && (idx_q == IW'(i))) begin
        lane_a_q[i] <= in_a;
        lane_b_q[i] <= in_b;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign vector_a[32*g +: 32] = lane_a_q[g];
    assign vector_b[32*g +: 32] = lane_b_q[g];
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign out_count = cnt_q;

endmodule

// File: tb/tb_dot_vector_loader.sv
// tb_dot_vector_loader: directed and randomized scoreboard bench
// for dot_vector_loader with N=4.
module tb_dot_vector_loader;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int W  = 32 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_last;
  logic [W-1:0]  vector_a;
  logic [W-1:0]  vector_b;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  dot_vector_loader #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .vector_a  (vector_a),
    .vector_b  (vector_b),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cnt;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   pushed  = 0;
  int   popped  = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int dot(input logic [W-1:0] a, input logic [W-1:0] b);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(a[32*i +: 32] * b[32*i +: 32]);
    return s;
  endfunction

  // Offer one pair; returns once the pair will be taken on the next edge.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                           input bit last, input int gap);
    int n = 0;
    int g = (gap > 0) ? $urandom_range(0, gap) : 0;
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom;
      in_b = $urandom;
      in_last = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0");
        break;
      end
    end
  endtask

  // Model: the first len pairs land in lanes 0..len-1, other lanes zero.
  task automatic send_vec(input int len, input logic [31:0] av[N],
                          input logic [31:0] bv[N], input bit last_full,
                          input int gap);
    exp_t e;
    e.a = '0;
    e.b = '0;
    e.cnt = len;
    for (int i = 0; i < len; i++) begin
      e.a[32*i +: 32] = av[i];
      e.b[32*i +: 32] = bv[i];
    end
    for (int i = 0; i < len; i++) begin
      bit l = (i == len - 1) ? ((len < N) ? 1'b1 : last_full) : 1'b0;
      send_pair(av[i], bv[i], l, gap);
    end
    q.push_back(e);
    pushed++;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_vec();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Monitor: compares every accepted vector with the scoreboard head and
  // checks that a held vector stays stable.
  initial begin
    logic [W-1:0]  pa;
    logic [W-1:0]  pb;
    logic [CW-1:0] pc;
    bit            hold = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (rst) begin
        hold = 1'b0;
        continue;
      end
      if (in_ready === out_valid) begin
        checks++;
        errors++;
        $display("FAIL ready_excl: in_ready %b out_valid %b", in_ready,
                 out_valid);
      end
      if (hold && out_valid) begin
        chk("hold_a", vector_a, pa);
        chk("hold_b", vector_b, pb);
        chk("hold_cnt", W'(out_count), W'(pc));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got count %0d expected none",
                   out_count);
        end else begin
          e = q.pop_front();
          popped++;
          chk("sb_vec_a", vector_a, e.a);
          chk("sb_vec_b", vector_b, e.b);
          chk("sb_count", W'(out_count), W'(e.cnt));
        end
      end
      hold = out_valid && !out_ready;
      pa = vector_a;
      pb = vector_b;
      pc = out_count;
    end
  end

  initial begin
    logic [31:0] av[N];
    logic [31:0] bv[N];
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_count", W'(out_count), W'(0));
    chk("rst_vec_a", vector_a, '0);
    chk("rst_vec_b", vector_b, '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst = 1'b0;

    // Full vector, consumer stalled
    av = '{32'd1, 32'd2, 32'd3, 32'd4};
    bv = '{32'd5, 32'd6, 32'd7, 32'd8};
    send_vec(4, av, bv, 1'b0, 0);
    idle();
    #1;
    chk("t1_valid", W'(out_valid), W'(1));
    chk("t1_count", W'(out_count), W'(4));
    chk("t1_vec_a", vector_a, 128'h00000004_00000003_00000002_00000001);
    chk("t1_vec_b", vector_b, 128'h00000008_00000007_00000006_00000005);
    chk("t1_dot", W'(dot(vector_a, vector_b)), W'(70));
    chk("t1_in_ready", W'(in_ready), W'(0));

    // Backpressure with new data offered
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      in_last = 1'($urandom_range(0, 1));
      #1;
      chk("t3_in_ready", W'(in_ready), W'(0));
      chk("t3_vec_a", vector_a, 128'h00000004_00000003_00000002_00000001);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("t3_valid_drop", W'(out_valid), W'(0));
    chk("t3_in_ready", W'(in_ready), W'(1));
    chk("t3_clr_a", vector_a, '0);
    chk("t3_clr_b", vector_b, '0);
    chk("t3_clr_cnt", W'(out_count), W'(0));

    // Short vector
    av = '{32'd3, 32'd4, 32'd0, 32'd0};
    bv = '{32'd3, 32'd4, 32'd0, 32'd0};
    send_vec(2, av, bv, 1'b0, 0);
    idle();
    #1;
    chk("t2_count", W'(out_count), W'(2));
    chk("t2_upper_a", vector_a >> 64, '0);
    chk("t2_upper_b", vector_b >> 64, '0);
    chk("t2_dot", W'(dot(vector_a, vector_b)), W'(25));
    release_vec();

    // Reuse after a short vector
    av = '{32'd9, 32'd0, 32'd0, 32'd0};
    bv = '{32'd9, 32'd0, 32'd0, 32'd0};
    send_vec(1, av, bv, 1'b0, 0);
    idle();
    release_vec();
    av = '{32'd1, 32'd1, 32'd1, 32'd1};
    bv = '{32'd1, 32'd1, 32'd1, 32'd1};
    send_vec(4, av, bv, 1'b0, 0);
    idle();
    #1;
    chk("t4_count", W'(out_count), W'(4));
    chk("t4_vec_a", vector_a, 128'h00000001_00000001_00000001_00000001);
    release_vec();

    // Reset mid-fill
    send_pair(32'hdead0001, 32'hbeef0001, 1'b0, 0);
    send_pair(32'hdead0002, 32'hbeef0002, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_valid", W'(out_valid), W'(0));
    chk("t5_vec_a", vector_a, '0);
    chk("t5_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < N; i++) begin
      av[i] = 32'h100 + i;
      bv[i] = 32'h200 + i;
    end
    send_vec(4, av, bv, 1'b1, 0);
    idle();
    #1;
    chk("t5_lane0", W'(vector_a[31:0]), W'(32'h100));
    release_vec();

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      int len = $urandom_range(1, N);
      for (int i = 0; i < N; i++) begin
        av[i] = $urandom;
        bv[i] = $urandom;
      end
      send_vec(len, av, bv, 1'($urandom_range(0, 1)), 2);
    end
    idle();
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", W'(q.size()), W'(0));
    chk("drain_count", W'(popped), W'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
